// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo counter family.
package counter_pkg;

  typedef enum logic {MODE_WRAP, MODE_SATURATE} count_mode_e;

  // Loads beyond the count range pin to the top value instead of aliasing.
  function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                             input logic [63:0] modulus);
    return (value >= modulus) ? modulus - 64'd1 : value;
  endfunction

  function automatic int pw(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated divider: tick is high on the last of every PRESCALE enabled cycles.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int            W    = pw(PRESCALE);
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr)  cnt_d = '0;
    else if (en)   cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescale, clear, load, wrap/saturate and cascade tc.
module mod_counter
  import counter_pkg::*;
#(
  parameter int              N        = 25,
  parameter longint unsigned MODULUS  = 64'd1 << N,
  parameter int              PRESCALE = 1,
  parameter int              SATURATE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         up,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap
);

  if (MODULUS < 64'd2 || MODULUS > (64'd1 << N)) begin : g_bad_modulus
    $fatal(1, "mod_counter: MODULUS must lie in 2..2**N");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "mod_counter: PRESCALE must be >= 1");
  end

  localparam logic [N-1:0] MAXV = N'(MODULUS - 64'd1);
  localparam count_mode_e  MODE = (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;

  logic         tick, step, at_top, at_bot;
  logic [N-1:0] q_q, q_d, ld_val;
  logic         wrap_q, wrap_d;

  if (PRESCALE > 1) begin : g_pre
    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (clr | load),
      .tick     (tick)
    );
  end else begin : g_nopre
    assign tick = 1'b1;
  end

  assign ld_val = N'(clamp_load(64'(load_val), MODULUS));
  assign at_top = (q_q == MAXV);
  assign at_bot = (q_q == '0);
  assign step   = en & tick & ~clr & ~load;

  // Cascade output deliberately ignores clr/load so chained stages see raw carry.
  assign tc   = en & tick & (up ? at_top : at_bot);
  assign q    = q_q;
  assign wrap = wrap_q;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = ld_val;
    end else if (step) begin
      if (up) begin
        if (!at_top) begin
          q_d = q_q + N'(1);
        end else if (MODE == MODE_WRAP) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          q_d = q_q - N'(1);
        end else if (MODE == MODE_WRAP) begin
          q_d    = MAXV;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: table-driven vectors plus multi-cycle corner sequences.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // a: N=4, MODULUS=10, wrap
  logic a_en, a_up, a_clr, a_ld, a_tc, a_wr;
  logic [3:0] a_lv, a_q;
  // s: N=4, MODULUS=10, saturate
  logic s_en, s_up, s_clr, s_ld, s_tc, s_wr;
  logic [3:0] s_lv, s_q;
  // p: N=4, MODULUS=4, PRESCALE=3
  logic p_en, p_up, p_clr, p_ld, p_tc, p_wr;
  logic [3:0] p_lv, p_q;
  // cascade lo(10) -> hi(6), plus natural-binary n (N=3, default modulus)
  logic c_en, lo_tc, lo_wr, hi_tc, hi_wr, n_tc, n_wr;
  logic [3:0] lo_q;
  logic [2:0] hi_q, n_q;

  mod_counter #(.N(4), .MODULUS(10)) u_a (
    .clk(clk), .reset(rst_n), .en(a_en), .clr(a_clr), .load(a_ld), .load_val(a_lv),
    .up(a_up), .q(a_q), .tc(a_tc), .wrap(a_wr));
  mod_counter #(.N(4), .MODULUS(10), .SATURATE(1)) u_s (
    .clk(clk), .reset(rst_n), .en(s_en), .clr(s_clr), .load(s_ld), .load_val(s_lv),
    .up(s_up), .q(s_q), .tc(s_tc), .wrap(s_wr));
  mod_counter #(.N(4), .MODULUS(4), .PRESCALE(3)) u_p (
    .clk(clk), .reset(rst_n), .en(p_en), .clr(p_clr), .load(p_ld), .load_val(p_lv),
    .up(p_up), .q(p_q), .tc(p_tc), .wrap(p_wr));
  mod_counter #(.N(4), .MODULUS(10)) u_lo (
    .clk(clk), .reset(rst_n), .en(c_en), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .up(1'b1), .q(lo_q), .tc(lo_tc), .wrap(lo_wr));
  mod_counter #(.N(3), .MODULUS(6)) u_hi (
    .clk(clk), .reset(rst_n), .en(lo_tc), .clr(1'b0), .load(1'b0), .load_val(3'd0),
    .up(1'b1), .q(hi_q), .tc(hi_tc), .wrap(hi_wr));
  mod_counter #(.N(3)) u_n (
    .clk(clk), .reset(rst_n), .en(c_en), .clr(1'b0), .load(1'b0), .load_val(3'd0),
    .up(1'b1), .q(n_q), .tc(n_tc), .wrap(n_wr));

  typedef struct {
    logic       en, up, clr, ld;
    logic [3:0] lv;
    logic       tc;   // expected before the edge
    logic [3:0] q;    // expected after the edge
    logic       wr;   // expected after the edge
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0, n_err = 0;
  int qm, pm, tcn;
  logic wexp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // en up clr ld lv  tc q wr
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd1,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd2,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd3,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd4,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd5,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd6,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd7,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd8,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd9,0});
    tbl.push_back('{1,1,0,0,4'd0, 1,4'd0,1});  // 9 -> 0 wraps
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd1,0});
    tbl.push_back('{1,1,0,0,4'd0, 0,4'd2,0});
    tbl.push_back('{1,0,0,0,4'd0, 0,4'd1,0});  // count down
    tbl.push_back('{1,0,0,0,4'd0, 0,4'd0,0});
    tbl.push_back('{1,0,0,0,4'd0, 1,4'd9,1});  // 0 -> 9 wraps
    tbl.push_back('{1,0,0,0,4'd0, 0,4'd8,0});
    tbl.push_back('{0,0,0,0,4'd0, 0,4'd8,0});  // en=0 holds
    tbl.push_back('{1,0,1,1,4'd5, 0,4'd0,0});  // clr beats load
    tbl.push_back('{0,1,0,1,4'd15,0,4'd9,0});  // clamp 15 -> 9
    tbl.push_back('{1,1,0,1,4'd3, 1,4'd3,0});  // tc ungated by load
    tbl.push_back('{0,1,0,1,4'd10,0,4'd9,0});  // clamp at MODULUS
    tbl.push_back('{0,1,0,1,4'd9, 0,4'd9,0});
    tbl.push_back('{1,1,0,0,4'd0, 1,4'd0,1});
    tbl.push_back('{1,1,0,1,4'd4, 0,4'd4,0});  // load kills wrap pulse
    tbl.push_back('{1,0,1,0,4'd0, 0,4'd0,0});
    tbl.push_back('{1,0,1,0,4'd0, 1,4'd0,0});  // tc ungated by clr
    tbl.push_back('{0,1,0,0,4'd0, 0,4'd0,0});

    {a_en, a_up, a_clr, a_ld, a_lv} = '0;
    {s_en, s_up, s_clr, s_ld, s_lv} = '0;
    {p_en, p_up, p_clr, p_ld, p_lv} = '0;
    c_en  = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst a_q", a_q, 0);   chk("rst a_wrap", a_wr, 0);
    chk("rst p_q", p_q, 0);   chk("rst n_q", n_q, 0);
    chk("rst a_tc", a_tc, 0);
    @(negedge clk) rst_n = 1'b1;
    edge_wait();

    foreach (tbl[i]) begin
      {a_en, a_up, a_clr, a_ld, a_lv} = {tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].ld, tbl[i].lv};
      #1 chk($sformatf("vec%0d tc", i), a_tc, tbl[i].tc);
      edge_wait();
      chk($sformatf("vec%0d q", i), a_q, tbl[i].q);
      chk($sformatf("vec%0d wrap", i), a_wr, tbl[i].wr);
    end
    {a_en, a_clr, a_ld} = '0;

    // saturating down-count from 7, then hold at the top
    s_ld = 1'b1; s_lv = 4'd7;
    edge_wait();
    chk("s load7", s_q, 7);
    s_ld = 1'b0; s_en = 1'b1; s_up = 1'b0;
    qm = 7;
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("s dn%0d tc", k), s_tc, qm == 0);
      edge_wait();
      if (qm > 0) qm--;
      chk($sformatf("s dn%0d q", k), s_q, qm);
      chk($sformatf("s dn%0d wrap", k), s_wr, 0);
    end
    s_ld = 1'b1; s_lv = 4'd12; s_up = 1'b1;
    edge_wait();
    chk("s clamp12", s_q, 9);
    s_ld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("s sat tc", s_tc, 1);
      edge_wait();
      chk("s sat q", s_q, 9);
      chk("s sat wrap", s_wr, 0);
    end
    s_en = 1'b0;

    // prescale 3: steps every third enabled cycle; en gap must not disturb phase
    p_up = 1'b1;
    qm = 0; pm = 0; tcn = 0;
    for (int k = 0; k < 18; k++) begin
      p_en = !(k == 13 || k == 14);
      #1 chk($sformatf("p%0d tc", k), p_tc, p_en && pm == 2 && qm == 3);
      if (k < 12 && p_tc) tcn++;
      edge_wait();
      wexp = 1'b0;
      if (p_en) begin
        if (pm == 2) begin
          pm = 0; wexp = (qm == 3); qm = (qm + 1) % 4;
        end else pm++;
      end
      chk($sformatf("p%0d q", k), p_q, qm);
      chk($sformatf("p%0d wrap", k), p_wr, wexp);
    end
    chk("p tc per 12", tcn, 1);
    p_en = 1'b0;

    // asynchronous reset mid-cycle with q=6 and a pending wrap on lo
    a_ld = 1'b1; a_lv = 4'd6; c_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      edge_wait();
      a_ld = 1'b0;
    end
    c_en = 1'b0;
    chk("pre-rst a_q", a_q, 6);
    chk("pre-rst lo_wrap", lo_wr, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async a_q", a_q, 0);     chk("async a_wrap", a_wr, 0);
    chk("async lo_wrap", lo_wr, 0); chk("async hi_q", hi_q, 0);
    chk("async p_q", p_q, 0);
    @(negedge clk) rst_n = 1'b1;
    p_en = 1'b1;
    edge_wait(); chk("p post-rst e1", p_q, 0);
    edge_wait(); chk("p post-rst e2", p_q, 0);
    edge_wait(); chk("p post-rst e3", p_q, 1);
    p_en = 1'b0;

    // cascade lo(10)->hi(6): 60-count sequence, natural binary alongside
    c_en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      chk($sformatf("c%0d lo", c), lo_q, c % 10);
      chk($sformatf("c%0d hi", c), hi_q, c / 10);
      chk($sformatf("c%0d lo_tc", c), lo_tc, (c % 10) == 9);
      chk($sformatf("c%0d hi_tc", c), hi_tc, c == 59);
      chk($sformatf("c%0d n", c), n_q, c % 8);
      chk($sformatf("c%0d n_tc", c), n_tc, (c % 8) == 7);
      edge_wait();
      chk($sformatf("c%0d lo_wrap", c), lo_wr, (c % 10) == 9);
      chk($sformatf("c%0d hi_wrap", c), hi_wr, c == 59);
      chk($sformatf("c%0d n_wrap", c), n_wr, (c % 8) == 7);
    end
    chk("c end lo", lo_q, 0);
    chk("c end hi", hi_q, 0);
    c_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
